// File: rtl/tt_noc_pkg.sv
// Shared NoC definitions: flit type codes, sink FSM states and flit field positions.
// Used by both the sink depacketizer and the source packetizer.
package tt_noc_pkg;

    typedef enum logic [1:0] {
        FLIT_BODY   = 2'b00,
        FLIT_TAIL   = 2'b01,
        FLIT_HEAD   = 2'b10,
        FLIT_SINGLE = 2'b11
    } flit_type_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        TIME    = 2'b01,
        PAYLOAD = 2'b10,
        DROP    = 2'b11
    } sink_state_e;

    localparam int FLIT_W        = 34;
    localparam int FLIT_TYPE_MSB = 33;
    localparam int FLIT_TYPE_LSB = 32;
    localparam int PORTID_MSB    = 31;
    localparam int PORTID_LSB    = 24;

endpackage

// File: rtl/tt_sink_depacketizer_if.sv
// Router-to-sink flit handshake bundle (flit, valid, ready) with master/slave views.
interface tt_sink_depacketizer_if
    import tt_noc_pkg::*;
#(
    parameter int VCHANNELS = 1
) (
    input logic clk
);

    logic [FLIT_W-1:0]    flit;
    logic [VCHANNELS-1:0] valid;
    logic [VCHANNELS-1:0] ready;

    modport master (input clk, output flit, output valid, input ready);
    modport slave  (input clk, input flit, input valid, output ready);

endinterface

// File: rtl/tt_sink_depacketizer.sv
// NoC sink: decodes HEAD/timestamp/payload/TAIL flits into port id, payload words,
// end-of-packet and transit latency, flagging malformed sequences as protocol errors.
module tt_sink_depacketizer
    import tt_noc_pkg::*;
#(
    parameter int FLIT_DATA_WIDTH = 32,
    parameter int FLIT_TYPE_WIDTH = 2,
    parameter int VCHANNELS       = 1,
    parameter int MAX_PAYLOAD     = 16
) (
    input  logic                                     clk,
    input  logic                                     reset_globle,
    input  logic [FLIT_TYPE_WIDTH+FLIT_DATA_WIDTH-1:0] flit_sink,
    input  logic [VCHANNELS-1:0]                     valid_sink,
    output logic [VCHANNELS-1:0]                     ready_sink,
    input  logic [63:0]                              GTB,
    output logic                                     portid_valid,
    output logic [7:0]                               sink_portid,
    output logic                                     write_en,
    output logic [31:0]                              sink_dataout,
    output logic                                     sink_terminate,
    output logic [31:0]                              rx_latency,
    output logic                                     latency_valid,
    output logic                                     proto_err,
    output logic [15:0]                              err_count
);

    localparam int CNT_W = $clog2(MAX_PAYLOAD + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PAYLOAD);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    sink_state_e          state_p1, state_nxt;
    logic [CNT_W-1:0]     cnt_p1, cnt_nxt;
    logic [31:0]          ts_p1, ts_nxt;
    logic                 rdy_arm_p1;
    logic [VCHANNELS-1:0] rdy_nxt;

    logic        pv_nxt, wr_nxt, term_nxt, lv_nxt, err_nxt;
    logic [7:0]  portid_nxt;
    logic [31:0] dout_nxt, lat_nxt;
    logic [15:0] errcnt_nxt;

    flit_type_e  ftype;
    logic [31:0] data;
    logic [31:0] now;
    logic        accept;
    logic        unused_gtb;

    assign ftype      = flit_type_e'(flit_sink[FLIT_TYPE_MSB:FLIT_TYPE_LSB]);
    assign data       = flit_sink[31:0];
    assign now        = GTB[31:0];
    assign accept     = valid_sink[0] & ready_sink[0];
    assign unused_gtb = ^GTB[63:32];

    // Only VC0 is served; ready rises on the second edge after reset release.
    always_comb begin
        rdy_nxt    = '0;
        rdy_nxt[0] = rdy_arm_p1;
    end

    always_comb begin
        state_nxt  = state_p1;
        cnt_nxt    = cnt_p1;
        ts_nxt     = ts_p1;
        pv_nxt     = 1'b0;
        wr_nxt     = 1'b0;
        term_nxt   = 1'b0;
        lv_nxt     = 1'b0;
        err_nxt    = 1'b0;
        portid_nxt = sink_portid;
        dout_nxt   = sink_dataout;
        lat_nxt    = rx_latency;

        if (accept) begin
            case (state_p1)
                IDLE, DROP: begin
                    case (ftype)
                        FLIT_HEAD: begin
                            pv_nxt     = 1'b1;
                            portid_nxt = data[PORTID_MSB:PORTID_LSB];
                            state_nxt  = TIME;
                        end
                        FLIT_SINGLE: begin
                            state_nxt = IDLE;
                            if (state_p1 == IDLE) begin
                                pv_nxt     = 1'b1;
                                portid_nxt = data[PORTID_MSB:PORTID_LSB];
                                term_nxt   = 1'b1;
                            end
                        end
                        default: begin
                            // Stray BODY/TAIL is an error when idle; while dropping, TAIL ends the drop
                            if (state_p1 == IDLE)
                                err_nxt = 1'b1;
                            else if (ftype == FLIT_TAIL)
                                state_nxt = IDLE;
                        end
                    endcase
                end
                default: begin
                    case (ftype)
                        FLIT_HEAD: begin
                            err_nxt    = 1'b1;
                            term_nxt   = 1'b1;
                            pv_nxt     = 1'b1;
                            portid_nxt = data[PORTID_MSB:PORTID_LSB];
                            state_nxt  = TIME;
                        end
                        FLIT_SINGLE: begin
                            err_nxt   = 1'b1;
                            term_nxt  = 1'b1;
                            state_nxt = IDLE;
                        end
                        FLIT_BODY: begin
                            if (state_p1 == TIME) begin
                                ts_nxt    = data;
                                cnt_nxt   = '0;
                                state_nxt = PAYLOAD;
                            end else if (cnt_p1 == CNT_MAX) begin
                                err_nxt   = 1'b1;
                                term_nxt  = 1'b1;
                                state_nxt = DROP;
                            end else begin
                                wr_nxt   = 1'b1;
                                dout_nxt = data;
                                cnt_nxt  = cnt_p1 + CNT_W'(1);
                            end
                        end
                        default: begin
                            term_nxt  = 1'b1;
                            lv_nxt    = 1'b1;
                            state_nxt = IDLE;
                            // Modulo-2^32 subtraction keeps latency correct across GTB wrap
                            if (state_p1 == TIME) begin
                                ts_nxt  = data;
                                lat_nxt = now - data;
                            end else begin
                                wr_nxt   = 1'b1;
                                dout_nxt = data;
                                lat_nxt  = now - ts_p1;
                            end
                        end
                    endcase
                end
            endcase
        end

        errcnt_nxt = err_nxt ? sat_inc16(err_count) : err_count;
    end

    always_ff @(posedge clk or posedge reset_globle) begin
        if (reset_globle) begin
            state_p1       <= IDLE;
            cnt_p1         <= '0;
            ts_p1          <= '0;
            rdy_arm_p1     <= 1'b0;
            ready_sink     <= '0;
            portid_valid   <= 1'b0;
            sink_portid    <= '0;
            write_en       <= 1'b0;
            sink_dataout   <= '0;
            sink_terminate <= 1'b0;
            rx_latency     <= '0;
            latency_valid  <= 1'b0;
            proto_err      <= 1'b0;
            err_count      <= '0;
        end else begin
            state_p1       <= state_nxt;
            cnt_p1         <= cnt_nxt;
            ts_p1          <= ts_nxt;
            rdy_arm_p1     <= 1'b1;
            ready_sink     <= rdy_nxt;
            portid_valid   <= pv_nxt;
            sink_portid    <= portid_nxt;
            write_en       <= wr_nxt;
            sink_dataout   <= dout_nxt;
            sink_terminate <= term_nxt;
            rx_latency     <= lat_nxt;
            latency_valid  <= lv_nxt;
            proto_err      <= err_nxt;
            err_count      <= errcnt_nxt;
        end
    end

endmodule

// File: tb/tb_tt_sink_depacketizer.sv
// Scoreboard bench for tt_sink_depacketizer: a packet-level reference model queues the
// expected output cycle for every accepted flit; a monitor compares every output pulse.
module tb_tt_sink_depacketizer;

    localparam int MAXP = 16;
    localparam logic [1:0] TB = 2'b00, TT = 2'b01, TH = 2'b10, TS = 2'b11;

    typedef struct packed {
        logic        pv;
        logic [7:0]  id;
        logic        wr;
        logic [31:0] d;
        logic        t;
        logic        lv;
        logic [31:0] lat;
        logic        e;
        logic [15:0] ec;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset_globle;
    logic [63:0] gtb;
    logic        portid_valid, write_en, sink_terminate, latency_valid, proto_err;
    logic [7:0]  sink_portid;
    logic [31:0] sink_dataout, rx_latency;
    logic [15:0] err_count;

    int checks = 0;
    int errors = 0;
    ev_t exp_q[$];

    // reference model state
    bit          m_in_pkt, m_have_ts, m_drop;
    int          m_n;
    logic [31:0] m_ts, m_d, m_lat;
    logic [7:0]  m_id;
    logic [15:0] m_ec;

    always #5 clk = ~clk;

    tt_sink_depacketizer_if #(.VCHANNELS(1)) bus (.clk(clk));

    tt_sink_depacketizer #(
        .FLIT_DATA_WIDTH(32), .FLIT_TYPE_WIDTH(2), .VCHANNELS(1), .MAX_PAYLOAD(MAXP)
    ) dut (
        .clk(clk), .reset_globle(reset_globle),
        .flit_sink(bus.flit), .valid_sink(bus.valid), .ready_sink(bus.ready),
        .GTB(gtb),
        .portid_valid(portid_valid), .sink_portid(sink_portid),
        .write_en(write_en), .sink_dataout(sink_dataout),
        .sink_terminate(sink_terminate), .rx_latency(rx_latency),
        .latency_valid(latency_valid), .proto_err(proto_err), .err_count(err_count)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, got, expv);
        end
    endtask

    task automatic model_reset();
        m_in_pkt = 0; m_have_ts = 0; m_drop = 0; m_n = 0;
        m_ts = '0; m_d = '0; m_lat = '0; m_id = '0; m_ec = '0;
        exp_q.delete();
    endtask

    // Packet-level view: in packet / timestamp seen / dropping, plus payload count.
    task automatic model(input logic [1:0] t, input logic [31:0] d, input logic [31:0] g);
        ev_t e;
        e = '0; e.id = m_id; e.d = m_d; e.lat = m_lat;
        if (m_drop && t == TB) begin
        end else if (m_drop && (t == TT || t == TS)) begin
            m_drop = 0;
        end else if (!m_in_pkt) begin
            m_drop = 0;
            if (t == TH) begin
                e.pv = 1; e.id = d[31:24]; m_in_pkt = 1; m_have_ts = 0;
            end else if (t == TS) begin
                e.pv = 1; e.id = d[31:24]; e.t = 1;
            end else begin
                e.e = 1;
            end
        end else begin
            case (t)
                TH: begin e.e = 1; e.t = 1; e.pv = 1; e.id = d[31:24]; m_have_ts = 0; end
                TS: begin e.e = 1; e.t = 1; m_in_pkt = 0; end
                TB: begin
                    if (!m_have_ts) begin
                        m_ts = d; m_have_ts = 1; m_n = 0;
                    end else if (m_n == MAXP) begin
                        e.e = 1; e.t = 1; m_in_pkt = 0; m_drop = 1;
                    end else begin
                        e.wr = 1; e.d = d; m_n++;
                    end
                end
                default: begin
                    e.t = 1; e.lv = 1; m_in_pkt = 0;
                    if (!m_have_ts) e.lat = g - d;
                    else begin e.wr = 1; e.d = d; e.lat = g - m_ts; end
                end
            endcase
        end
        if (e.e && m_ec != 16'hFFFF) m_ec = m_ec + 16'd1;
        e.ec = m_ec;
        m_id = e.id; m_d = e.d; m_lat = e.lat;
        if (e.pv | e.wr | e.t | e.lv | e.e) exp_q.push_back(e);
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input logic [1:0] t, input logic [31:0] d, input logic [31:0] g, input int gap);
        int w;
        if (gap > 0) begin
            bus.valid = '0;
            repeat (gap) @(negedge clk);
        end
        w = 0;
        while (bus.ready[0] !== 1'b1 && w < 20) begin
            bus.valid = '0;
            @(negedge clk);
            w++;
        end
        if (w >= 20) begin
            checks++; errors++;
            $display("FAIL ready_timeout got ready=%0b expected 1", bus.ready[0]);
        end else begin
            bus.flit  = {t, d};
            bus.valid = 1'b1;
            gtb       = {$urandom, g};
            model(t, d, g);
            @(negedge clk);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ready"}, 64'(bus.ready), 64'd0);
        chk({nm, "_pulses"}, {59'd0, portid_valid, write_en, sink_terminate, latency_valid, proto_err}, 64'd0);
        chk({nm, "_portid"}, 64'(sink_portid), 64'd0);
        chk({nm, "_dataout"}, 64'(sink_dataout), 64'd0);
        chk({nm, "_latency"}, 64'(rx_latency), 64'd0);
        chk({nm, "_errcnt"}, 64'(err_count), 64'd0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset_globle = 1'b0;
        @(posedge clk); #1;
        chk("ready_edge1", 64'(bus.ready[0]), 64'd0);
        @(posedge clk); #1;
        chk("ready_edge2", 64'(bus.ready[0]), 64'd1);
        @(negedge clk);
    endtask

    // Monitor: every cycle with any pulse must match the next queued expectation.
    initial begin
        ev_t got, expv;
        forever begin
            @(negedge clk);
            if (reset_globle !== 1'b1 &&
                (portid_valid | write_en | sink_terminate | latency_valid | proto_err) === 1'b1) begin
                got = '{portid_valid, sink_portid, write_en, sink_dataout, sink_terminate,
                        latency_valid, rx_latency, proto_err, err_count};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output got pv%0b id%02h wr%0b d%08h t%0b lv%0b lat%08h e%0b ec%0d expected no pulse",
                             got.pv, got.id, got.wr, got.d, got.t, got.lv, got.lat, got.e, got.ec);
                end else begin
                    expv = exp_q.pop_front();
                    if (got !== expv) begin
                        errors++;
                        $display("FAIL output_event got pv%0b id%02h wr%0b d%08h t%0b lv%0b lat%08h e%0b ec%0d expected pv%0b id%02h wr%0b d%08h t%0b lv%0b lat%08h e%0b ec%0d",
                                 got.pv, got.id, got.wr, got.d, got.t, got.lv, got.lat, got.e, got.ec,
                                 expv.pv, expv.id, expv.wr, expv.d, expv.t, expv.lv, expv.lat, expv.e, expv.ec);
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] g0;
        int n;
        reset_globle = 1'b1;
        bus.valid    = '0;
        bus.flit     = '0;
        gtb          = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        release_reset();

        // basic packet with two payload words
        send(TH, 32'h0500_0000, 32'h0, 0);
        send(TB, 32'h0000_0100, 32'h0, 0);
        send(TB, 32'hAAAA_0001, 32'h0, 1);
        send(TT, 32'hBBBB_0002, 32'h180, 0);

        // timestamp wrap, without and with payload
        send(TH, 32'h0700_0000, 32'h0, 0);
        send(TB, 32'hFFFF_FFF0, 32'h0, 0);
        send(TT, 32'h1234_5678, 32'h0000_0010, 0);
        send(TH, 32'h0800_0000, 32'h0, 0);
        send(TB, 32'hFFFF_FFF0, 32'h0, 0);
        send(TB, 32'h1111_2222, 32'h0, 0);
        send(TT, 32'h3333_4444, 32'h0000_0010, 2);

        // BODY in IDLE, then HEAD inside PAYLOAD
        send(TB, 32'hDEAD_BEEF, 32'h0, 0);
        send(TH, 32'h0A00_0000, 32'h0, 0);
        send(TB, 32'h0000_1000, 32'h0, 0);
        send(TB, 32'h5555_0001, 32'h0, 0);
        send(TH, 32'h0B00_0000, 32'h0, 0);
        send(TB, 32'h0000_2000, 32'h0, 0);
        send(TT, 32'h6666_0002, 32'h0000_2005, 0);
        chk("err_count_after_abort", 64'(err_count), 64'd2);

        // payload overflow, drop until TAIL, then a normal packet
        send(TH, 32'h0C00_0000, 32'h0, 0);
        send(TB, 32'h0000_0050, 32'h0, 0);
        for (int i = 0; i <= MAXP; i++) send(TB, 32'hC000_0000 + 32'(i), 32'h0, 0);
        send(TB, 32'hD000_0001, 32'h0, 0);
        send(TB, 32'hD000_0002, 32'h0, 1);
        send(TT, 32'hD000_0003, 32'h0, 0);
        send(TH, 32'h0D00_0000, 32'h0, 0);
        send(TB, 32'h0000_0060, 32'h0, 0);
        send(TB, 32'hE000_0001, 32'h0, 0);
        send(TT, 32'hE000_0002, 32'h0000_0070, 0);

        // SINGLE in IDLE
        send(TS, 32'h0900_0000, 32'h0, 0);

        // reset after the second payload flit
        send(TH, 32'h0F00_0000, 32'h0, 0);
        send(TB, 32'h0000_0200, 32'h0, 0);
        send(TB, 32'hF000_0001, 32'h0, 0);
        send(TB, 32'hF000_0002, 32'h0, 0);
        #2;
        reset_globle = 1'b1;
        #1;
        chk_all_zero("midpkt_reset");
        chk("queue_empty_at_reset", 64'(exp_q.size()), 64'd0);
        model_reset();
        bus.valid = '0;
        @(posedge clk);
        release_reset();
        send(TT, 32'hF000_0003, 32'h0, 0);

        // randomized packets with occasional stray flits
        for (int p = 0; p < 40; p++) begin
            n  = $urandom_range(0, MAXP + 2);
            g0 = $urandom;
            send(TH, $urandom, $urandom, $urandom_range(0, 2));
            send(TB, g0, $urandom, $urandom_range(0, 2));
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 15) == 0)
                    send(2'($urandom), $urandom, $urandom, $urandom_range(0, 2));
                else
                    send(TB, $urandom, $urandom, $urandom_range(0, 2));
            end
            send(TT, $urandom, g0 + $urandom_range(0, 100000), $urandom_range(0, 2));
            if ($urandom_range(0, 4) == 0)
                send(2'($urandom), $urandom, $urandom, $urandom_range(0, 2));
        end

        bus.valid = '0;
        repeat (4) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        chk("final_err_count", 64'(err_count), 64'(m_ec));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
